// File: rtl/ifid_fetch_queue_pkg.sv
// Shared types and helpers for the IF/ID fetch queue.
// INSTR_NOP is what decode sees whenever the queue is empty.
package ifid_pkg;

  localparam int IFID_INSTR_W = 32;
  localparam int IFID_PC_W    = 32;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [IFID_INSTR_W-1:0] instr;
    logic [IFID_PC_W-1:0]    pcadd4;
  } ifid_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifid_fetch_queue_if.sv
// Enqueue (IF side) and dequeue (ID side) handshake groups of the fetch queue.
// master = fetch/decode stages, slave = the queue itself.
interface ifid_fetch_queue_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4
);
  import ifid_pkg::*;

  localparam int CW = cnt_w(DEPTH);

  logic               enq_valid;
  logic               enq_ready;
  logic [INSTR_W-1:0] enq_instr;
  logic [PC_W-1:0]    enq_pcadd4;

  logic               deq_valid;
  logic               deq_ready;
  logic [INSTR_W-1:0] deq_instr;
  logic [PC_W-1:0]    deq_pcadd4;

  logic [CW-1:0]      count;

  modport master (
    output enq_valid, enq_instr, enq_pcadd4, deq_ready,
    input  enq_ready, deq_valid, deq_instr, deq_pcadd4, count
  );

  modport slave (
    input  enq_valid, enq_instr, enq_pcadd4, deq_ready,
    output enq_ready, deq_valid, deq_instr, deq_pcadd4, count
  );

endinterface

// File: rtl/ifid_fetch_queue.sv
// DEPTH-entry IF/ID queue; enqueued entry visible on deq one edge later (no bypass).
// enq_ready depends on occupancy only (no pass-through when full); flush/reset empty it next edge.
module ifid_fetch_queue
  import ifid_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  ifid_fetch_queue_if.slave q
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pcadd4;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          enq_fire;
  logic          deq_fire;

  assign q.enq_ready  = (cnt != FULL);
  assign q.deq_valid  = (cnt != '0);
  assign q.count      = cnt;
  assign q.deq_instr  = q.deq_valid ? mem[head].instr  : INSTR_W'(INSTR_NOP);
  assign q.deq_pcadd4 = q.deq_valid ? mem[head].pcadd4 : '0;

  assign enq_fire = q.enq_valid & q.enq_ready & ~flush;
  assign deq_fire = q.deq_valid & q.deq_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq_fire) tail <= tail + PW'(1);
      if (deq_fire) head <= head + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && enq_fire) begin
      mem[tail] <= '{instr: q.enq_instr, pcadd4: q.enq_pcadd4};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (cnt <= FULL)
        else $error("ifid_fetch_queue: count %0d exceeds depth", cnt);
      assert (PW'(tail - head) == PW'(cnt))
        else $error("ifid_fetch_queue: pointer distance disagrees with count");
    end
  end

endmodule

// File: doc/ifid_fetch_queue.md
Name: ifid_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched instructions, each with its PC+4, between the IF and ID stages.
- IF may keep fetching while ID is stalled; the buffered instructions absorb the stall.
- Valid/ready handshakes on both sides; a single flush drops all buffered and in-flight fetches on a branch/jump redirect.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, PC+4 width in bits.
- DEPTH, 4, number of queue entries; power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- flush  input  1  discard all entries and the same-cycle enqueue.
- enq_valid  input  1  IF presents a fetched instruction.
- enq_ready  output  1  queue can accept an entry this cycle.
- enq_instr  input  INSTR_W  fetched instruction.
- enq_pcadd4  input  PC_W  PC+4 of the fetched instruction.
- deq_valid  output  1  head entry available to ID.
- deq_ready  input  1  ID consumes the head; driven as ~Stall.
- deq_instr  output  INSTR_W  head instruction; NOP when empty.
- deq_pcadd4  output  PC_W  head PC+4; 0 when empty.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: circular buffer with head and tail pointers, each $clog2(DEPTH) bits, plus a registered count. Pointers wrap modulo DEPTH.
- Handshakes:
  - enq fire = enq_valid & enq_ready & ~flush.
  - deq fire = deq_valid & deq_ready & ~flush.
  - enq_ready = (count != DEPTH). It is combinational from count only and never depends on deq_ready (no pass-through when full).
  - deq_valid = (count != 0).
- Latency: an entry enqueued at edge N is visible on deq_* after edge N. There is no combinational bypass from enq to deq, so an empty queue gives one cycle of latency.
- Output values:
  - deq_instr/deq_pcadd4 are driven from the head entry when deq_valid = 1.
  - When deq_valid = 0, deq_instr = NOP (all-zero, sll $0,$0,0) and deq_pcadd4 = 0.
- Occupancy update (no flush):
  - enq only: count+1, tail+1.
  - deq only: count-1, head+1.
  - both: count unchanged, both pointers advance. This is legal at any occupancy 1..DEPTH-1.
  - At count = DEPTH, enq is blocked; a deq still fires and the tail is untouched.
- Flush has priority over everything:
  - On the next edge, head = tail = 0 and count = 0.
  - A simultaneous enq is dropped and a simultaneous deq is not counted.
  - The entry payload RAM is not cleared; only the pointers are.
- Reset (rst_n = 0 at an edge):
  - Same effect as flush, valid at any time including mid-operation.
  - After reset: enq_ready = 1, deq_valid = 0, deq_instr = NOP, deq_pcadd4 = 0, count = 0.
- enq_valid while enq_ready = 0: ignored. IF must hold its data; the queue samples nothing.
- deq_ready while empty: no effect; count never underflows.
- Protocol assertions:
  - count ≤ DEPTH always.
  - (tail - head) mod DEPTH equals count mod DEPTH.

Decomposition:
- Shared package ifid_pkg:
  - constant INSTR_NOP (32'h0000_0000).
  - typedef ifid_entry_t, a packed struct {instr, pcadd4}.
  - function clog2-based width helpers for count/pointer widths.
- The existing IF interface gains a modport pair matching the enq_* and deq_* port groups.
- No sub-module. Pointer/count logic and the entry array live in this module; the generic ring-buffer logic is too small to justify splitting out.

Test Plan:
- Reset then idle: rst_n = 0 for 2 cycles, then 1 → count = 0, enq_ready = 1, deq_valid = 0, deq_instr = 0x00000000, deq_pcadd4 = 0.
- Fill with stall, DEPTH = 4: deq_ready = 0; enqueue 0x20080001..0x20080004 with pcadd4 0x4..0x10 → count reaches 4, enq_ready = 0. A fifth enq_valid with 0x20080005 is ignored. Release deq_ready → outputs 0x20080001..0x20080004 in order, one per cycle, then deq_valid = 0.
- Steady streaming: enq and deq every cycle from count = 1 for 20 cycles → count stays 1, order preserved, pointers wrap 5 times with no loss or duplication.
- Flush mid-stream: count = 3, assert flush together with enq_valid (0x1000FFFF) and deq_ready → next cycle count = 0, deq_valid = 0, deq_instr = NOP. The 0x1000FFFF entry never appears at deq.
- Full with simultaneous deq: count = 4, enq_valid = 1, deq_ready = 1 → head dequeued, enq not accepted, count = 3. Next cycle enq_ready = 1 and the enq is accepted.
- Reset mid-operation: count = 2, rst_n = 0 for one edge → all outputs at reset values. The first enqueue after reset appears at deq after exactly one edge.
